// File: rtl/sync_glitch_filter.sv
// Multi-channel input conditioner: per-channel metastability synchronizer,
// enable-gated saturating-count glitch filter and registered edge pulses.
module sync_glitch_filter #(
  parameter int   NUM_CH     = 1,
  parameter int   NUM_STAGES = 3,
  parameter int   FILTER_LEN = 4,
  parameter logic RESET_VAL  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NUM_CH-1:0] data_in,
  output logic [NUM_CH-1:0] data_out,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall
);

  if (NUM_CH < 1) begin : g_bad_num_ch
    $error("sync_glitch_filter: NUM_CH must be >= 1");
  end
  if (NUM_STAGES < 2) begin : g_bad_num_stages
    $error("sync_glitch_filter: NUM_STAGES must be >= 2");
  end
  if (FILTER_LEN < 1) begin : g_bad_filter_len
    $error("sync_glitch_filter: FILTER_LEN must be >= 1");
  end

  localparam int CNT_W = (FILTER_LEN < 1) ? 1 : $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);

  logic [NUM_STAGES-1:0] sync_q [NUM_CH];
  logic [CNT_W-1:0]      cnt_q  [NUM_CH];
  logic [NUM_CH-1:0]     sync;

  always_comb begin
    sync = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      sync[c] = sync_q[c][NUM_STAGES-1];
    end
  end

  // Synchronizer stage 0 takes the raw pin; the oldest stage feeds the filter.
  // A differing sample only wins after FILTER_LEN consecutive enabled edges;
  // any enabled match with data_out restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        sync_q[c] <= {NUM_STAGES{RESET_VAL}};
        cnt_q[c]  <= '0;
      end
      data_out <= {NUM_CH{RESET_VAL}};
      rise     <= '0;
      fall     <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        sync_q[c] <= {sync_q[c][NUM_STAGES-2:0], data_in[c]};
        rise[c]   <= 1'b0;
        fall[c]   <= 1'b0;
        if (en) begin
          if (sync[c] == data_out[c]) begin
            cnt_q[c] <= '0;
          end else if (cnt_q[c] < CNT_MAX) begin
            cnt_q[c] <= cnt_q[c] + CNT_W'(1);
          end else begin
            cnt_q[c]    <= '0;
            data_out[c] <= sync[c];
            rise[c]     <= sync[c];
            fall[c]     <= ~sync[c];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sync_glitch_filter.sv
// Scoreboard bench for sync_glitch_filter: a 4-channel FILTER_LEN=4 instance
// and a 1-channel FILTER_LEN=1 instance sharing clk, rst_n and en.
module tb_sync_glitch_filter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] data_in;
  logic [3:0] data_out;
  logic [3:0] rise;
  logic [3:0] fall;
  logic [0:0] data_in_b;
  logic [0:0] data_out_b;
  logic [0:0] rise_b;
  logic [0:0] fall_b;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] o;
    logic [3:0] r;
    logic [3:0] f;
    logic       ob;
    logic       rb;
    logic       fb;
    string      tag;
  } exp_t;

  exp_t exp_q [$];

  sync_glitch_filter #(
    .NUM_CH(4), .NUM_STAGES(3), .FILTER_LEN(4), .RESET_VAL(1'b1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en),
    .data_in(data_in), .data_out(data_out), .rise(rise), .fall(fall)
  );

  sync_glitch_filter #(
    .NUM_CH(1), .NUM_STAGES(3), .FILTER_LEN(1), .RESET_VAL(1'b1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en),
    .data_in(data_in_b), .data_out(data_out_b), .rise(rise_b), .fall(fall_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue n edges with the current inputs; each edge queues the outputs
  // expected right after it.
  task automatic cyc(input int n, input logic [3:0] o, input logic [3:0] r,
                     input logic [3:0] f, input logic ob, input logic rb,
                     input logic fb, input string tag);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      e.o = o; e.r = r; e.f = f;
      e.ob = ob; e.rb = rb; e.fb = fb;
      e.tag = tag;
      exp_q.push_back(e);
      #1;
    end
  endtask

  task automatic cyc_a(input int n, input logic [3:0] o, input logic [3:0] r,
                       input logic [3:0] f, input string tag);
    cyc(n, o, r, f, 1'b1, 1'b0, 1'b0, tag);
  endtask

  // Monitor: compare on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if ({data_out, rise, fall} !== {e.o, e.r, e.f}) begin
        bad++;
        $display("FAIL %s ch4: got out=%b rise=%b fall=%b, want out=%b rise=%b fall=%b (t=%0t)",
                 e.tag, data_out, rise, fall, e.o, e.r, e.f, $time);
      end
      total++;
      if ({data_out_b, rise_b, fall_b} !== {e.ob, e.rb, e.fb}) begin
        bad++;
        $display("FAIL %s len1: got out=%b rise=%b fall=%b, want out=%b rise=%b fall=%b (t=%0t)",
                 e.tag, data_out_b, rise_b, fall_b, e.ob, e.rb, e.fb, $time);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    en        = 1'b1;
    data_in   = 4'h0;
    data_in_b = 1'b1;

    // power-up: idle-high reset value, then all channels fall on edge 7
    cyc_a(3, 4'hF, 4'h0, 4'h0, "reset_hold");
    rst_n = 1'b1;
    cyc_a(6, 4'hF, 4'h0, 4'h0, "release_wait");
    cyc_a(1, 4'h0, 4'h0, 4'hF, "release_fall");
    data_in = 4'hF;
    cyc_a(6, 4'h0, 4'h0, 4'h0, "all_rise_wait");
    cyc_a(1, 4'hF, 4'hF, 4'h0, "all_rise");
    cyc_a(1, 4'hF, 4'h0, 4'h0, "all_rise_end");

    // clean edge on channel 0
    data_in = 4'hE;
    cyc_a(6, 4'hF, 4'h0, 4'h0, "clean_fall_wait");
    cyc_a(1, 4'hE, 4'h0, 4'h1, "clean_fall");
    cyc_a(1, 4'hE, 4'h0, 4'h0, "clean_fall_end");
    data_in = 4'hF;
    cyc_a(6, 4'hE, 4'h0, 4'h0, "clean_rise_wait");
    cyc_a(1, 4'hF, 4'h1, 4'h0, "clean_rise");
    cyc_a(1, 4'hF, 4'h0, 4'h0, "clean_rise_end");

    // 3-cycle low glitch is rejected
    data_in = 4'hE;
    cyc_a(3, 4'hF, 4'h0, 4'h0, "glitch3_low");
    data_in = 4'hF;
    cyc_a(8, 4'hF, 4'h0, 4'h0, "glitch3_reject");

    // 4-cycle low pulse passes as exactly 4 low cycles
    data_in = 4'hE;
    cyc_a(4, 4'hF, 4'h0, 4'h0, "pulse4_low");
    data_in = 4'hF;
    cyc_a(2, 4'hF, 4'h0, 4'h0, "pulse4_wait");
    cyc_a(1, 4'hE, 4'h0, 4'h1, "pulse4_fall");
    cyc_a(3, 4'hE, 4'h0, 4'h0, "pulse4_held");
    cyc_a(1, 4'hF, 4'h1, 4'h0, "pulse4_rise");
    cyc_a(2, 4'hF, 4'h0, 4'h0, "pulse4_end");

    // gated enable: en on every 4th edge
    data_in = 4'hE;
    for (int k = 1; k <= 16; k++) begin
      en = (k % 4 == 0);
      cyc_a(1, (k == 16) ? 4'hE : 4'hF, 4'h0, (k == 16) ? 4'h1 : 4'h0, "gated_fall");
    end
    data_in = 4'hF;
    for (int k = 17; k <= 32; k++) begin
      en = (k % 4 == 0);
      cyc_a(1, (k == 32) ? 4'hF : 4'hE, (k == 32) ? 4'h1 : 4'h0, 4'h0, "gated_rise");
    end
    for (int k = 33; k <= 48; k++) begin
      en = (k % 4 == 0);
      data_in = (k <= 38) ? 4'hE : 4'hF;
      cyc_a(1, 4'hF, 4'h0, 4'h0, "gated_glitch6");
    end
    en = 1'b1;

    // multichannel: channel 2 alone
    data_in = 4'hB;
    cyc_a(6, 4'hF, 4'h0, 4'h0, "ch2_fall_wait");
    cyc_a(1, 4'hB, 4'h0, 4'h4, "ch2_fall");
    cyc_a(1, 4'hB, 4'h0, 4'h0, "ch2_fall_end");
    data_in = 4'hF;
    cyc_a(6, 4'hB, 4'h0, 4'h0, "ch2_rise_wait");
    cyc_a(1, 4'hF, 4'h4, 4'h0, "ch2_rise");
    cyc_a(1, 4'hF, 4'h0, 4'h0, "ch2_rise_end");

    // opposite simultaneous edges on channels 0 and 1
    data_in = 4'hD;
    cyc_a(6, 4'hF, 4'h0, 4'h0, "ch1_fall_wait");
    cyc_a(1, 4'hD, 4'h0, 4'h2, "ch1_fall");
    data_in = 4'hE;
    cyc_a(6, 4'hD, 4'h0, 4'h0, "opp_wait");
    cyc_a(1, 4'hE, 4'h2, 4'h1, "opp_edges");
    data_in = 4'hF;
    cyc_a(6, 4'hE, 4'h0, 4'h0, "ch0_rise_wait");
    cyc_a(1, 4'hF, 4'h1, 4'h0, "ch0_rise");
    cyc_a(1, 4'hF, 4'h0, 4'h0, "ch0_rise_end");

    // reset after 2 of 4 counts: pending change discarded, full restart
    data_in = 4'hE;
    cyc_a(5, 4'hF, 4'h0, 4'h0, "midcnt_count");
    rst_n = 1'b0;
    cyc_a(2, 4'hF, 4'h0, 4'h0, "midcnt_reset");
    rst_n = 1'b1;
    cyc_a(6, 4'hF, 4'h0, 4'h0, "midcnt_restart");
    cyc_a(1, 4'hE, 4'h0, 4'h1, "midcnt_fall");
    data_in = 4'hF;
    cyc_a(6, 4'hE, 4'h0, 4'h0, "midcnt_rise_wait");
    cyc_a(1, 4'hF, 4'h1, 4'h0, "midcnt_rise");
    cyc_a(1, 4'hF, 4'h0, 4'h0, "midcnt_rise_end");

    // FILTER_LEN=1: output moves on edge NUM_STAGES+1
    data_in_b = 1'b0;
    cyc(3, 4'hF, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, "len1_fall_wait");
    cyc(1, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, "len1_fall");
    cyc(1, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, "len1_fall_end");
    data_in_b = 1'b1;
    cyc(3, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, "len1_rise_wait");
    cyc(1, 4'hF, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, "len1_rise");
    cyc(1, 4'hF, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, "len1_rise_end");
    data_in_b = 1'b0;
    cyc(1, 4'hF, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, "len1_pulse_low");
    data_in_b = 1'b1;
    cyc(2, 4'hF, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, "len1_pulse_wait");
    cyc(1, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, "len1_pulse_fall");
    cyc(1, 4'hF, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, "len1_pulse_rise");
    cyc(1, 4'hF, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, "len1_pulse_end");

    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_glitch_filter.md
# sync_glitch_filter

Multi-channel input conditioner: per channel, a NUM_STAGES-deep metastability synchronizer, a saturating-count glitch filter gated by a sample enable, and registered rise/fall edge pulses. Successor to the single-bit synchronizer. It sits between asynchronous pins (UART RX, CTS, break detect) and the receive logic. It is typically driven with `en` from the oversample tick counter.

## Interface
Parameters:
- NUM_CH, default 1: number of independent channels (>=1).
- NUM_STAGES, default 3: synchronizer flops per channel (>=2).
- FILTER_LEN, default 4: consecutive enabled differing samples required to change the output (>=1).
- RESET_VAL, default 1: reset level of every synchronizer flop and every `data_out` bit (1 means idle UART line).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; asynchronous, active-low.
- en  input  1  filter sample enable; synchronizer runs every cycle regardless.
- data_in  input  NUM_CH  asynchronous inputs.
- data_out  output  NUM_CH  filtered, synchronized levels.
- rise  output  NUM_CH  one-cycle pulse, data_out went 0->1.
- fall  output  NUM_CH  one-cycle pulse, data_out went 1->0.

## Operation
- Parameter violations (NUM_STAGES<2, FILTER_LEN<1, NUM_CH<1) are elaboration errors.
- Per channel, `sync` is the oldest synchronizer stage. The chain shifts every clk, newest sample in at stage 0.
- Per channel filter counter `cnt`, width $clog2(FILTER_LEN+1), range 0..FILTER_LEN-1.
- On a clk edge with en=0: cnt and data_out hold. rise and fall deassert.
- On a clk edge with en=1 and sync==data_out: cnt<=0.
- On a clk edge with en=1, sync!=data_out, and cnt<FILTER_LEN-1: cnt<=cnt+1.
- On a clk edge with en=1, sync!=data_out, and cnt==FILTER_LEN-1: data_out<=sync and cnt<=0. On the same edge, rise<=sync or fall<=~sync.
- A reversion to data_out's value during counting clears cnt. Counting does not accumulate across glitches.
- FILTER_LEN=1: data_out follows sync on every enabled edge; the counter is degenerate (width 1, always 0).
- rise and fall are registered and never both high on one channel. Each is high exactly one cycle per transition and is otherwise 0.
- Channels are fully independent. They share only clk, rst_n, and en.

## Timing
- Reset (asynchronous assert): all synchronizer flops = RESET_VAL, data_out = {NUM_CH{RESET_VAL}}, cnt = 0, rise = 0, fall = 0. Release is synchronous to clk (the release synchronizer is external).
- Reset mid-count: the pending change is discarded and no pulse is generated. After release the channel behaves as from power-up.
- Latency with en held high: data_in changes and is stable before edge 1. sync shows the new value after edge NUM_STAGES. data_out, with rise/fall, updates on edge NUM_STAGES+FILTER_LEN.
- With a gated en, the filter needs FILTER_LEN enabled edges at which sync differs. Unenabled edges neither count nor clear.
- Rejection: a level at sync lasting fewer than FILTER_LEN enabled samples never reaches data_out.
- A pulse is coincident with the first cycle data_out shows the new value.
- Back-to-back transitions are at minimum FILTER_LEN enabled edges apart. A new pulse never overlaps a previous one.

## Test plan
- Reset: hold rst_n=0 with data_in=0 and RESET_VAL=1 -> data_out=1, rise=0, fall=0. Release with data_in=0 and en=1 -> fall pulses on edge 7 (NUM_STAGES=3, FILTER_LEN=4).
- Clean edge (NUM_STAGES=3, FILTER_LEN=4, en=1): data_in 1->0 before edge 1 -> data_out=0 and fall=1 after edge 7. fall=0 after edge 8. rise stays 0.
- Glitch rejection: data_in low for 3 cycles, then high -> data_out stays 1, no pulses. A 4-cycle low pulse -> data_out low for exactly 4 cycles, one fall and one rise.
- Gated enable: en high on every 4th cycle, data_in held low -> data_out falls on the 4th enabled edge after sync goes low. A 6-cycle low glitch (at most 2 enabled samples) is rejected.
- Multichannel (NUM_CH=4): toggle channel 2 only -> only data_out[2], rise[2], and fall[2] change. Simultaneous opposite edges on channels 0 and 1 -> fall[0] and rise[1] in the same cycle.
- Reset mid-count: assert rst_n after 2 of 4 counts -> cnt=0, data_out=RESET_VAL, no pulse. FILTER_LEN=1 variant -> data_out updates on edge NUM_STAGES+1.
